// File: rtl/rv32_pkg.sv
// rv32_pkg: types shared by the writeback arbiter and its result FIFO.
//   wb_entry_t : one buffered register-file write (file select, rd, data).
package rv32_pkg;

  typedef struct packed {
    logic        fp;    // 1 = FP register file, 0 = integer register file
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rv32_writeback_arbiter_if.sv
// rv32_writeback_arbiter_if: result-source handshakes into the writeback arbiter.
//   pipe_* : in-order pipeline result, held upstream while pipe_stall_o is high.
//   lu_*   : long-latency unit (divide/FP) result, valid/ready handshake.
// master = result sources, slave = arbiter.
interface rv32_writeback_arbiter_if;
  logic        pipe_valid_i;
  logic        pipe_fp_i;
  logic [4:0]  pipe_rd_i;
  logic [31:0] pipe_data_i;
  logic        pipe_stall_o;

  logic        lu_valid_i;
  logic        lu_ready_o;
  logic        lu_fp_i;
  logic [4:0]  lu_rd_i;
  logic [31:0] lu_data_i;

  modport master (
    output pipe_valid_i, pipe_fp_i, pipe_rd_i, pipe_data_i,
    input  pipe_stall_o,
    output lu_valid_i, lu_fp_i, lu_rd_i, lu_data_i,
    input  lu_ready_o
  );

  modport slave (
    input  pipe_valid_i, pipe_fp_i, pipe_rd_i, pipe_data_i,
    output pipe_stall_o,
    input  lu_valid_i, lu_fp_i, lu_rd_i, lu_data_i,
    output lu_ready_o
  );
endinterface

// File: rtl/rv32_wb_fifo.sv
// rv32_wb_fifo: FIFO of pending long-latency writeback entries.
//   clk_i, rst_n_i : clock, async active-low reset (clears pointers and count)
//   push_i, din_i  : enqueue (ignored when full)
//   pop_i, dout_o  : dequeue; dout_o shows the head whenever not empty
//   full_o, empty_o, count_o : occupancy status
module rv32_wb_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  wb_entry_t                    din_i,
  output wb_entry_t                    dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_o == CW'(DEPTH));
  assign empty_o = (count_o == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count/pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din_i;
  end

endmodule

// File: rtl/rv32_writeback_arbiter.sv
// rv32_writeback_arbiter: merges pipeline and long-latency results onto the
// integer and FP register-file write ports, one arbitration per file.
//   clk_i, rst_n_i   : clock, async active-low reset
//   wb (slave)       : pipeline and long-latency source handshakes
//   reg_write_*_o    : registered integer write port (x0 writes suppressed)
//   fp_reg_write_*_o : registered FP write port
//   buffer_count_o   : long-latency FIFO occupancy
// Optional feature macro: RV32_WB_BYPASS_EN -- a long-latency result that finds
// the FIFO empty and its file unclaimed is written directly (1-cycle latency).
module rv32_writeback_arbiter
  import rv32_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  rv32_writeback_arbiter_if.slave           wb,
  output logic                              reg_write_enable_o,
  output logic [4:0]                        reg_write_address_o,
  output logic [31:0]                       reg_write_data_o,
  output logic                              fp_reg_write_enable_o,
  output logic [4:0]                        fp_reg_write_address_o,
  output logic [31:0]                       fp_reg_write_data_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   buffer_count_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t       head;
  wb_entry_t       lu_entry;
  wb_entry_t       pipe_entry;
  wb_entry_t       int_d;
  wb_entry_t       fp_d;
  logic            int_we_d;
  logic            fp_we_d;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic            pipe_accept;
  logic            lu_fire;
  logic            head_blocked;
  logic            bypass;
  logic [SW-1:0]   starve_cnt;

  assign lu_entry   = '{fp: wb.lu_fp_i,   rd: wb.lu_rd_i,   data: wb.lu_data_i};
  assign pipe_entry = '{fp: wb.pipe_fp_i, rd: wb.pipe_rd_i, data: wb.pipe_data_i};

  assign wb.pipe_stall_o = (starve_cnt == SW'(STARVE_LIMIT));
  assign wb.lu_ready_o   = !fifo_full;

  assign pipe_accept  = wb.pipe_valid_i && !wb.pipe_stall_o;
  assign lu_fire      = wb.lu_valid_i && wb.lu_ready_o;
  // The pipeline wins its own file unless the head has starved long enough
  // to force a stall, at which point pipe_accept drops and the head goes.
  assign head_blocked = !fifo_empty && pipe_accept && (wb.pipe_fp_i == head.fp);
  assign fifo_pop     = !fifo_empty && !head_blocked;

`ifdef RV32_WB_BYPASS_EN
  assign bypass = lu_fire && fifo_empty && !(pipe_accept && (wb.pipe_fp_i == wb.lu_fp_i));
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = lu_fire && !bypass;

  rv32_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (lu_entry),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (buffer_count_o)
  );

  // At most one source per file can be selected: pop excludes a same-file
  // pipeline write, and bypass only fires when the FIFO is empty.
  always_comb begin
    int_we_d = 1'b0;
    fp_we_d  = 1'b0;
    int_d    = '0;
    fp_d     = '0;
    if (pipe_accept) begin
      if (pipe_entry.fp) begin fp_we_d = 1'b1;  fp_d = pipe_entry; end
      else               begin int_we_d = 1'b1; int_d = pipe_entry; end
    end
    if (fifo_pop) begin
      if (head.fp) begin fp_we_d = 1'b1;  fp_d = head; end
      else         begin int_we_d = 1'b1; int_d = head; end
    end
    if (bypass) begin
      if (lu_entry.fp) begin fp_we_d = 1'b1;  fp_d = lu_entry; end
      else             begin int_we_d = 1'b1; int_d = lu_entry; end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      reg_write_enable_o     <= 1'b0;
      reg_write_address_o    <= '0;
      reg_write_data_o       <= '0;
      fp_reg_write_enable_o  <= 1'b0;
      fp_reg_write_address_o <= '0;
      fp_reg_write_data_o    <= '0;
    end else begin
      // x0 is hardwired zero; the entry is consumed but never written.
      reg_write_enable_o    <= int_we_d && (int_d.rd != 5'd0);
      fp_reg_write_enable_o <= fp_we_d;
      if (int_we_d && (int_d.rd != 5'd0)) begin
        reg_write_address_o <= int_d.rd;
        reg_write_data_o    <= int_d.data;
      end
      if (fp_we_d) begin
        fp_reg_write_address_o <= fp_d.rd;
        fp_reg_write_data_o    <= fp_d.data;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_cnt <= '0;
    end else if (fifo_pop) begin
      starve_cnt <= '0;
    end else if (head_blocked && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32_writeback_arbiter.sv
module tb_rv32_writeback_arbiter;
  import rv32_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we, fwe;
  logic [4:0]  wa, fwa;
  logic [31:0] wd, fwd;
  logic [$clog2(DEPTH+1)-1:0] cnt;

  int errors = 0;
  int checks = 0;

  rv32_writeback_arbiter_if wb();

  rv32_writeback_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i                  (clk),
    .rst_n_i                (rst_n),
    .wb                     (wb),
    .reg_write_enable_o     (we),
    .reg_write_address_o    (wa),
    .reg_write_data_o       (wd),
    .fp_reg_write_enable_o  (fwe),
    .fp_reg_write_address_o (fwa),
    .fp_reg_write_data_o    (fwd),
    .buffer_count_o         (cnt)
  );

  always #5 clk = ~clk;

  // Reference model: pending long-latency results and blocked-cycle count.
  wb_entry_t q[$];
  int        starve = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive sources, check combinational status, predict and
  // check the registered writes. Returns whether the pipe result was taken.
  task automatic step(input logic pv, input logic pfp, input logic [4:0] prd,
                      input logic [31:0] pd, input logic lv, input logic lfp,
                      input logic [4:0] lrd, input logic [31:0] ld,
                      output logic accepted);
    logic exp_stall, exp_ready, accept, push, pop, blocked, byp;
    logic e_we, e_fwe;
    logic [4:0] e_wa, e_fwa;
    logic [31:0] e_wd, e_fwd;
    wb.pipe_valid_i = pv; wb.pipe_fp_i = pfp; wb.pipe_rd_i = prd; wb.pipe_data_i = pd;
    wb.lu_valid_i = lv;   wb.lu_fp_i = lfp;   wb.lu_rd_i = lrd;   wb.lu_data_i = ld;
    #1;
    exp_stall = (starve == LIMIT);
    exp_ready = (q.size() < DEPTH);
    chk("pipe_stall", 32'(wb.pipe_stall_o), 32'(exp_stall));
    chk("lu_ready",   32'(wb.lu_ready_o),   32'(exp_ready));
    chk("count",      32'(cnt),             32'(q.size()));
    accept  = pv && !exp_stall;
    push    = lv && exp_ready;
    pop     = (q.size() > 0) && !(accept && pfp == q[0].fp);
    blocked = (q.size() > 0) && !pop;
    byp     = 1'b0;
`ifdef RV32_WB_BYPASS_EN
    byp = push && q.size() == 0 && !(accept && pfp == lfp);
`endif
    e_we = 0; e_fwe = 0; e_wa = 0; e_fwa = 0; e_wd = 0; e_fwd = 0;
    if (accept) begin
      if (pfp) begin e_fwe = 1; e_fwa = prd; e_fwd = pd; end
      else if (prd != 0) begin e_we = 1; e_wa = prd; e_wd = pd; end
    end
    if (pop) begin
      if (q[0].fp) begin e_fwe = 1; e_fwa = q[0].rd; e_fwd = q[0].data; end
      else if (q[0].rd != 0) begin e_we = 1; e_wa = q[0].rd; e_wd = q[0].data; end
    end
    if (byp) begin
      if (lfp) begin e_fwe = 1; e_fwa = lrd; e_fwd = ld; end
      else if (lrd != 0) begin e_we = 1; e_wa = lrd; e_wd = ld; end
    end
    if (pop) void'(q.pop_front());
    if (push && !byp) q.push_back('{fp: lfp, rd: lrd, data: ld});
    if (pop) starve = 0;
    else if (blocked && starve < LIMIT) starve++;
    @(posedge clk);
    #1;
    chk("int_we", 32'(we), 32'(e_we));
    if (e_we) begin
      chk("int_addr", 32'(wa), 32'(e_wa));
      chk("int_data", wd, e_wd);
    end
    chk("fp_we", 32'(fwe), 32'(e_fwe));
    if (e_fwe) begin
      chk("fp_addr", 32'(fwa), 32'(e_fwa));
      chk("fp_data", fwd, e_fwd);
    end
    accepted = accept;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, a);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    32'(we),  0);
    chk({tag, "_wa"},    32'(wa),  0);
    chk({tag, "_wd"},    wd,       0);
    chk({tag, "_fwe"},   32'(fwe), 0);
    chk({tag, "_fwa"},   32'(fwa), 0);
    chk({tag, "_fwd"},   fwd,      0);
    chk({tag, "_cnt"},   32'(cnt), 0);
    chk({tag, "_stall"}, 32'(wb.pipe_stall_o), 0);
    chk({tag, "_ready"}, 32'(wb.lu_ready_o),   1);
  endtask

  initial begin
    logic a;
    logic pv, pfp, lv, lfp;
    logic [4:0] prd, lrd;
    logic [31:0] pd, ld;

    wb.pipe_valid_i = 0; wb.pipe_fp_i = 0; wb.pipe_rd_i = 0; wb.pipe_data_i = 0;
    wb.lu_valid_i = 0;   wb.lu_fp_i = 0;   wb.lu_rd_i = 0;   wb.lu_data_i = 0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Pipeline-only integer write.
    step(1, 0, 5'd5, 32'h1234, 0, 0, 0, 0, a);
    chk("x5_direct_we", 32'(we), 1);
    chk("x5_direct_wd", wd, 32'h1234);
    idle(1);

    // Pipe int x3 with lu FP f7 in the same cycle.
    step(1, 0, 5'd3, 32'h33, 1, 1, 5'd7, 32'hCAFE, a);
    idle(2);

    // Starvation: lu x9 buffered, four blocking pipe writes, then forced stall.
    step(0, 0, 0, 0, 1, 0, 5'd9, 32'h99, a);
    for (int i = 1; i <= 4; i++) step(1, 0, 5'(i), 32'(i), 0, 0, 0, 0, a);
    step(1, 0, 5'd12, 32'hC12, 0, 0, 0, 0, a);
    chk("stall_holds_pipe", 32'(a), 0);
    chk("stall_grants_x9", 32'(wa), 9);
    step(1, 0, 5'd12, 32'hC12, 0, 0, 0, 0, a);
    chk("held_pipe_taken", 32'(a), 1);
    idle(1);

    // Fill with the int file blocked, third push refused, then drain in order.
    step(1, 0, 5'd1, 32'h1, 1, 0, 5'd20, 32'hA0, a);
    step(1, 0, 5'd2, 32'h2, 1, 0, 5'd21, 32'hA1, a);
    step(1, 0, 5'd4, 32'h4, 1, 0, 5'd22, 32'hA2, a);
    chk("full_ready_low", 32'(wb.lu_ready_o), 0);
    idle(3);

    // x0 from both sources: nothing written, entry still consumed.
    step(1, 0, 5'd0, 32'hDEAD, 1, 0, 5'd0, 32'hBEEF, a);
    idle(2);

    // Reset in the middle of a drain with two entries buffered.
    step(1, 0, 5'd6, 32'h6, 1, 0, 5'd10, 32'hB0, a);
    step(1, 0, 5'd7, 32'h7, 1, 0, 5'd11, 32'hB1, a);
    chk("pre_reset_count", 32'(cnt), 2);
    wb.pipe_valid_i = 0; wb.lu_valid_i = 0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    repeat (2) begin
      @(posedge clk); #1;
      chk("in_reset_we", 32'(we), 0);
      chk("in_reset_fwe", 32'(fwe), 0);
    end
    @(negedge clk) rst_n = 1'b1;
    q.delete();
    starve = 0;
    @(posedge clk); #1;
    idle(3);

    // Randomized traffic; a stalled pipe result is held unchanged upstream.
    pv = 0; pfp = 0; prd = 0; pd = 0; a = 1;
    for (int n = 0; n < 400; n++) begin
      if (!(pv && !a)) begin
        pv  = ($urandom_range(0, 99) < 65);
        pfp = ($urandom_range(0, 99) < 30);
        prd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        pd  = $urandom;
      end
      lv  = ($urandom_range(0, 99) < 45);
      lfp = ($urandom_range(0, 99) < 40);
      lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      ld  = $urandom;
      step(pv, pfp, prd, pd, lv, lfp, lrd, ld, a);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32_writeback_arbiter.md
RV32_WRITEBACK_ARBITER -- requirements
Module: rv32_writeback_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2: number of buffered long-latency results.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: consecutive blocked cycles before a forced pipeline stall.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, listed first:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
REQ-004 SHALL have these pipeline result ports:
- pipe_valid_i  in  1  pipeline result present.
- pipe_fp_i  in  1  destination is the FP file (1) or the integer file (0).
- pipe_rd_i  in  5  destination register.
- pipe_data_i  in  32  result data.
- pipe_stall_o  out  1  pipeline result not accepted; hold it this cycle.
REQ-005 SHALL have these long-latency unit (divide/FP) ports:
- lu_valid_i  in  1  long-latency result present.
- lu_ready_o  out  1  buffer can accept.
- lu_fp_i  in  1  destination file select.
- lu_rd_i  in  5  destination register.
- lu_data_i  in  32  result data.
REQ-006 SHALL have these register-file write ports:
- reg_write_enable_o  out  1  integer write enable.
- reg_write_address_o  out  5  integer write address.
- reg_write_data_o  out  32  integer write data.
- fp_reg_write_enable_o  out  1  FP write enable.
- fp_reg_write_address_o  out  5  FP write address.
- fp_reg_write_data_o  out  32  FP write data.
REQ-007 SHALL have buffer_count_o  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Function
REQ-008 All write-port outputs SHALL be registered; a granted source drives its write enable in the cycle after the grant.
REQ-009 An accepted pipeline result SHALL produce a write enable exactly 1 cycle after the cycle in which pipe_valid_i=1 and pipe_stall_o=0.
REQ-010 Long-latency results SHALL be pushed into the FIFO when lu_valid_i && lu_ready_o; lu_ready_o = (count < FIFO_DEPTH), independent of lu_valid_i.
REQ-011 Arbitration SHALL be per register file: the FIFO head is popped in a cycle unless the pipeline presents a valid result to the same file (pipe_fp_i == head.fp) and pipe_stall_o=0.
REQ-012 An integer and an FP write MAY occur in the same cycle from different sources.
REQ-013 The starvation counter SHALL increment on each cycle in which the FIFO head is blocked per REQ-011, clear on every pop, and saturate at STARVE_LIMIT.
REQ-014 pipe_stall_o SHALL be combinational = (starve_cnt == STARVE_LIMIT); while it is high, the head is granted, the pipeline result is not written, and the upstream holds it.
REQ-015 Integer writes to x0 (from either source) SHALL be suppressed (enable stays 0); x0 entries still pop from the FIFO. FP f0 SHALL be written normally.
REQ-016 Push and pop in the same cycle SHALL leave the count unchanged; a push while full cannot occur because lu_ready_o=0.
REQ-017 FIFO order SHALL be strictly first-in-first-out; pointers wrap modulo FIFO_DEPTH.
REQ-018 Minimum long-latency latency (handshake cycle to write enable) SHALL be 2 cycles.

Reset
REQ-019 On reset assertion, the block SHALL immediately clear all write enables, addresses and data, FIFO pointers, count, and starve_cnt, and set pipe_stall_o=0. lu_ready_o SHALL be 1 after reset.
REQ-020 Reset asserted mid-operation SHALL discard buffered entries; no write SHALL issue while rst_n_i=0.

Configuration
REQ-021 Macro RV32_WB_BYPASS_EN: when defined, a long-latency result arriving while the FIFO is empty and its file is not claimed by the pipeline SHALL bypass the FIFO, giving 1-cycle latency without occupying an entry. When undefined, every result goes through the FIFO (REQ-018).

Structure
REQ-022 Typedef wb_entry_t {fp, rd[4:0], data[31:0]} SHALL reside in the shared package rv32_pkg.
REQ-023 The FIFO SHALL be the single sub-module rv32_wb_fifo (parameterised depth, push/pop/full/empty/count).

Verification
REQ-024 Pipe int x5=0x1234 alone -> reg_write_enable_o=1, address 5, data 0x1234 one cycle later.
REQ-025 Pipe int x3 and lu FP f7=0xCAFE together -> int write x3 at +1; f7 write at +2 (+1 with RV32_WB_BYPASS_EN).
REQ-026 Lu int x9 pushed, then pipe int writes on 4 consecutive cycles -> pipe_stall_o=1 on the 5th cycle, x9 written, and the held pipe result written the cycle after.
REQ-027 Three lu pushes with FIFO_DEPTH=2 and pipe blocking the int file -> lu_ready_o=0 after 2 pushes; order preserved on drain; buffer_count_o goes 2 -> 1 -> 0.
REQ-028 Lu int x0 and pipe int x0 -> no integer write enable; FIFO still pops.
REQ-029 Reset mid-drain with 2 entries -> all outputs 0, buffer_count_o=0, no write after release.
